// File: rtl/m68k_bus_ctrl.sv
// rtl/m68k_bus_ctrl.sv - M68K bus-cycle DTACK generator with SDRAM-backed program ROM reads
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   cpu_as_n          68K address strobe (active low)
//   cpu_rw            1 = read, 0 = write
//   cpu_a             word address A23..A1
//   prog_rom_cs       chip select: program ROM
//   ram_cs            chip select: work RAM
//   shared_ram_cs     chip select: shared RAM
//   pal_cs            chip select: either palette
//   io_cs             chip select: any register
//   rom_ack/rom_data  one-cycle SDRAM completion pulse and its read word
//   cpu_dtack_n       DTACK to the CPU
//   rom_req/rom_addr  level request to SDRAM and the word address latched with it
//   rom_dout          latched ROM word, valid while DTACK is low
//   rom_timeout       sticky flag: a ROM read was force-acknowledged
module m68k_bus_ctrl #(
   parameter int RAM_WAIT    = 2,
   parameter int PAL_WAIT    = 3,
   parameter int IO_WAIT     = 1,
   parameter int OPEN_WAIT   = 4,
   parameter int ROM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_as_n,
   input  logic        cpu_rw,
   input  logic [22:0] cpu_a,
   input  logic        prog_rom_cs,
   input  logic        ram_cs,
   input  logic        shared_ram_cs,
   input  logic        pal_cs,
   input  logic        io_cs,
   input  logic        rom_ack,
   input  logic [15:0] rom_data,
   output logic        cpu_dtack_n,
   output logic        rom_req,
   output logic [22:0] rom_addr,
   output logic [15:0] rom_dout,
   output logic        rom_timeout
);

   localparam logic [2:0] ST_SYNC     = 3'd0;
   localparam logic [2:0] ST_IDLE     = 3'd1;
   localparam logic [2:0] ST_SETTLE   = 3'd2;
   localparam logic [2:0] ST_ROM_WAIT = 3'd3;
   localparam logic [2:0] ST_COUNT    = 3'd4;
   localparam logic [2:0] ST_ACK      = 3'd5;

   localparam int TO_W = $clog2(ROM_TIMEOUT + 1);

   // The cycle-start and SETTLE cycles already account for two of the N
   // wait cycles, so the counter is loaded with N-2 (clamped at 0).
   function automatic logic [3:0] wait_load(input int n);
      if (n <= 2) wait_load = 4'd0;
      else        wait_load = 4'(n - 2);
   endfunction

   localparam logic [3:0]      RAM_LOAD  = wait_load(RAM_WAIT);
   localparam logic [3:0]      PAL_LOAD  = wait_load(PAL_WAIT);
   localparam logic [3:0]      IO_LOAD   = wait_load(IO_WAIT);
   localparam logic [3:0]      OPEN_LOAD = wait_load(OPEN_WAIT);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(ROM_TIMEOUT - 1);

   logic [2:0]      state_q, state_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic [TO_W-1:0] tcnt_q, tcnt_d;
   logic            dtack_n_q, dtack_n_d;
   logic            rom_req_q, rom_req_d;
   logic [22:0]     rom_addr_q, rom_addr_d;
   logic [15:0]     rom_dout_q, rom_dout_d;
   logic            rom_timeout_q, rom_timeout_d;

   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      tcnt_d        = tcnt_q;
      dtack_n_d     = dtack_n_q;
      rom_req_d     = rom_req_q;
      rom_addr_d    = rom_addr_q;
      rom_dout_d    = rom_dout_q;
      rom_timeout_d = rom_timeout_q;

      case (state_q)
         // A strobe already low when reset releases belongs to a cycle we
         // never saw start, so wait for it to end first.
         ST_SYNC: begin
            if (cpu_as_n) state_d = ST_IDLE;
         end

         ST_IDLE: begin
            if (!cpu_as_n) state_d = ST_SETTLE;
         end

         ST_SETTLE: begin
            if (cpu_as_n) begin
               state_d = ST_IDLE;
            end else if (prog_rom_cs && cpu_rw) begin
               rom_req_d  = 1'b1;
               rom_addr_d = cpu_a;
               tcnt_d     = '0;
               state_d    = ST_ROM_WAIT;
            end else begin
               // A ROM write falls through to the open-bus timing.
               state_d = ST_COUNT;
               if (prog_rom_cs)                  wcnt_d = OPEN_LOAD;
               else if (ram_cs || shared_ram_cs) wcnt_d = RAM_LOAD;
               else if (pal_cs)                  wcnt_d = PAL_LOAD;
               else if (io_cs)                   wcnt_d = IO_LOAD;
               else                              wcnt_d = OPEN_LOAD;
            end
         end

         // DTACK is dropped on the edge that enters ACK so that the latency
         // counted from cycle start is exactly the region's wait count.
         ST_ROM_WAIT: begin
            if (cpu_as_n) begin
               rom_req_d = 1'b0;
               state_d   = ST_IDLE;
            end else if (rom_ack) begin
               rom_req_d  = 1'b0;
               rom_dout_d = rom_data;
               dtack_n_d  = 1'b0;
               state_d    = ST_ACK;
            end else if (tcnt_q == TO_LAST) begin
               rom_req_d     = 1'b0;
               rom_dout_d    = 16'hFFFF;
               rom_timeout_d = 1'b1;
               dtack_n_d     = 1'b0;
               state_d       = ST_ACK;
            end else if (tcnt_q != '1) begin
               tcnt_d = tcnt_q + TO_W'(1);
            end
         end

         ST_COUNT: begin
            if (cpu_as_n) begin
               state_d = ST_IDLE;
            end else if (wcnt_q == 4'd0) begin
               dtack_n_d = 1'b0;
               state_d   = ST_ACK;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end

         ST_ACK: begin
            if (cpu_as_n) begin
               dtack_n_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end

         default: state_d = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_SYNC;
         wcnt_q        <= 4'd0;
         tcnt_q        <= '0;
         dtack_n_q     <= 1'b1;
         rom_req_q     <= 1'b0;
         rom_addr_q    <= 23'd0;
         rom_dout_q    <= 16'hFFFF;
         rom_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wcnt_q        <= wcnt_d;
         tcnt_q        <= tcnt_d;
         dtack_n_q     <= dtack_n_d;
         rom_req_q     <= rom_req_d;
         rom_addr_q    <= rom_addr_d;
         rom_dout_q    <= rom_dout_d;
         rom_timeout_q <= rom_timeout_d;
      end
   end

   assign cpu_dtack_n = dtack_n_q;
   assign rom_req     = rom_req_q;
   assign rom_addr    = rom_addr_q;
   assign rom_dout    = rom_dout_q;
   assign rom_timeout = rom_timeout_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// tb/tb_m68k_bus_ctrl.sv - scoreboard bench for m68k_bus_ctrl
module tb_m68k_bus_ctrl;

   localparam int RAM_W  = 2;
   localparam int PAL_W  = 3;
   localparam int IO_W   = 1;
   localparam int OPEN_W = 4;
   localparam int ROM_TO = 255;

   localparam int K_REQ_RISE = 0;
   localparam int K_REQ_FALL = 1;
   localparam int K_DT_FALL  = 2;
   localparam int K_DT_RISE  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_as_n;
   logic        cpu_rw;
   logic [22:0] cpu_a;
   logic        prog_rom_cs, ram_cs, shared_ram_cs, pal_cs, io_cs;
   logic        rom_ack;
   logic [15:0] rom_data;
   logic        cpu_dtack_n;
   logic        rom_req;
   logic [22:0] rom_addr;
   logic [15:0] rom_dout;
   logic        rom_timeout;

   m68k_bus_ctrl #(
      .RAM_WAIT   (RAM_W),
      .PAL_WAIT   (PAL_W),
      .IO_WAIT    (IO_W),
      .OPEN_WAIT  (OPEN_W),
      .ROM_TIMEOUT(ROM_TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_as_n     (cpu_as_n),
      .cpu_rw       (cpu_rw),
      .cpu_a        (cpu_a),
      .prog_rom_cs  (prog_rom_cs),
      .ram_cs       (ram_cs),
      .shared_ram_cs(shared_ram_cs),
      .pal_cs       (pal_cs),
      .io_cs        (io_cs),
      .rom_ack      (rom_ack),
      .rom_data     (rom_data),
      .cpu_dtack_n  (cpu_dtack_n),
      .rom_req      (rom_req),
      .rom_addr     (rom_addr),
      .rom_dout     (rom_dout),
      .rom_timeout  (rom_timeout)
   );

   always #5 clk = ~clk;

   // cyc equals k after the k-th rising edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          kind;
      int          cyc;
      logic [22:0] addr;
      logic [15:0] dout;
      logic        tflag;
   } ev_t;

   ev_t evq[$];

   // Reference model state: what rom_dout / rom_timeout should hold.
   logic [15:0] m_dout;
   logic        m_to;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int c, input logic [22:0] a);
      ev_t e;
      e.kind  = kind;
      e.cyc   = c;
      e.addr  = a;
      e.dout  = m_dout;
      e.tflag = m_to;
      evq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   // Wait count for a non-ROM-read cycle, straight from the region rules.
   function automatic int lat_of(input bit rom, input bit ram, input bit sh, input bit pal, input bit io);
      int n;
      if (rom)            n = OPEN_W;
      else if (ram || sh) n = RAM_W;
      else if (pal)       n = PAL_W;
      else if (io)        n = IO_W;
      else                n = OPEN_W;
      return (n < 2) ? 2 : n;
   endfunction

   // ---------------- monitor ----------------
   task automatic take(input int kind);
      ev_t e;
      if (evq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
         return;
      end
      e = evq.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_cycle", 32'(cyc), 32'(e.cyc));
      case (kind)
         K_REQ_RISE: chk("rom_addr", 32'(rom_addr), 32'(e.addr));
         K_DT_FALL: begin
            chk("rom_dout", 32'(rom_dout), 32'(e.dout));
            chk("rom_timeout_ack", 32'(rom_timeout), 32'(e.tflag));
         end
         K_DT_RISE: chk("rom_timeout_end", 32'(rom_timeout), 32'(e.tflag));
         default: ;
      endcase
   endtask

   initial begin : monitor
      logic req_p, dt_p;
      wait (mon_en);
      @(negedge clk);
      req_p = rom_req;
      dt_p  = cpu_dtack_n;
      forever begin
         @(negedge clk);
         if (!req_p && rom_req)      take(K_REQ_RISE);
         if (req_p && !rom_req)      take(K_REQ_FALL);
         if (dt_p && !cpu_dtack_n)   take(K_DT_FALL);
         if (!dt_p && cpu_dtack_n)   take(K_DT_RISE);
         req_p = rom_req;
         dt_p  = cpu_dtack_n;
      end
   end

   // ---------------- driver ----------------
   task automatic release_bus();
      cpu_as_n      = 1'b1;
      prog_rom_cs   = 1'b0;
      ram_cs        = 1'b0;
      shared_ram_cs = 1'b0;
      pal_cs        = 1'b0;
      io_cs         = 1'b0;
   endtask

   // ack_d: ROM read acked on the ack_d-th edge after entering ROM_WAIT (0 = never)
   // abort_j: 0 = none; otherwise strobe rises to abort the cycle
   task automatic bus_cycle(input bit rom, input bit ram, input bit sh, input bit pal, input bit io,
                            input bit rw, input logic [22:0] addr, input int ack_d,
                            input int abort_j, input logic [15:0] data);
      int start, fin, lat;
      tick();
      cpu_a         = addr;
      cpu_rw        = rw;
      prog_rom_cs   = rom;
      ram_cs        = ram;
      shared_ram_cs = sh;
      pal_cs        = pal;
      io_cs         = io;
      cpu_as_n      = 1'b0;
      start         = cyc + 1;
      if (rom && rw) begin
         push(K_REQ_RISE, start + 1, addr);
         if (abort_j > 0) begin
            push(K_REQ_FALL, start + 1 + abort_j, addr);
            wait_until(start + abort_j);
            release_bus();
            tick();
            return;
         end
         if (ack_d > 0 && ack_d <= ROM_TO) begin
            fin    = start + 1 + ack_d;
            m_dout = data;
         end else begin
            fin    = start + 1 + ROM_TO;
            m_dout = 16'hFFFF;
            m_to   = 1'b1;
         end
         push(K_REQ_FALL, fin, addr);
         push(K_DT_FALL, fin, addr);
         if (ack_d > 0 && ack_d <= ROM_TO) begin
            wait_until(fin - 1);
            rom_ack  = 1'b1;
            rom_data = data;
            tick();
            rom_ack  = 1'b0;
            rom_data = 16'($urandom);
         end else begin
            wait_until(fin);
         end
      end else begin
         lat = lat_of(rom, ram, sh, pal, io);
         if (abort_j > 0) begin
            wait_until(start + abort_j - 1);
            release_bus();
            tick();
            return;
         end
         fin = start + lat;
         push(K_DT_FALL, fin, addr);
         wait_until(fin);
      end
      repeat ($urandom_range(0, 2)) tick();
      release_bus();
      push(K_DT_RISE, cyc + 1, addr);
      tick();
   endtask

   task automatic stray_ack(input logic [15:0] data);
      tick();
      rom_ack  = 1'b1;
      rom_data = data;
      tick();
      rom_ack  = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dtack_n"}, 32'(cpu_dtack_n), 32'd1);
      chk({tag, "_rom_req"}, 32'(rom_req), 32'd0);
      chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
      chk({tag, "_rom_dout"}, 32'(rom_dout), 32'hFFFF);
      chk({tag, "_rom_timeout"}, 32'(rom_timeout), 32'd0);
   endtask

   initial begin : driver
      bit r_rom, r_ram, r_sh, r_pal, r_io, r_rw;
      int r_abort, r_ack, start;

      reset         = 1'b1;
      cpu_as_n      = 1'b0;
      cpu_rw        = 1'b1;
      cpu_a         = 23'd0;
      prog_rom_cs   = 1'b0;
      ram_cs        = 1'b0;
      shared_ram_cs = 1'b0;
      pal_cs        = 1'b0;
      io_cs         = 1'b0;
      rom_ack       = 1'b0;
      rom_data      = 16'h0000;
      m_dout        = 16'hFFFF;
      m_to          = 1'b0;

      repeat (3) tick();
      chk_reset_vals("reset");
      mon_en = 1'b1;
      reset  = 1'b0;
      // Strobe already low at reset release: must never be acknowledged.
      repeat (6) tick();
      release_bus();
      repeat (2) tick();

      bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 23'h001234, 0, 0, 16'h0);
      bus_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h002000, 0, 0, 16'h0);
      bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23'h000100, 6, 0, 16'hBEEF);
      bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 23'h000200, 3, 0, 16'hCAFE);
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23'h7FFFFF, 0, 0, 16'h0);
      bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 23'h000300, 0, 0, 16'h0);
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h400000, 0, 0, 16'h0);
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 23'h500000, 0, 0, 16'h0);
      bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23'h000400, 10, 2, 16'h0);
      stray_ack(16'h1234);
      bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 23'h001000, 0, 0, 16'h0);
      bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23'h000500, ROM_TO, 0, 16'h5A5A);
      bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23'h000600, 0, 0, 16'h0);
      bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 23'h001002, 0, 0, 16'h0);

      for (int i = 0; i < 40; i++) begin
         r_rom = ($urandom_range(0, 2) == 0);
         r_ram = ($urandom_range(0, 2) == 0);
         r_sh  = ($urandom_range(0, 3) == 0);
         r_pal = ($urandom_range(0, 2) == 0);
         r_io  = ($urandom_range(0, 2) == 0);
         r_rw  = ($urandom_range(0, 3) != 0);
         r_ack = $urandom_range(1, 12);
         r_abort = 0;
         if ($urandom_range(0, 5) == 0) begin
            if (r_rom && r_rw) r_abort = $urandom_range(1, 4);
            else               r_abort = $urandom_range(1, lat_of(r_rom, r_ram, r_sh, r_pal, r_io) - 1);
         end
         bus_cycle(r_rom, r_ram, r_sh, r_pal, r_io, r_rw, 23'($urandom), r_ack, r_abort, 16'($urandom));
         if ($urandom_range(0, 3) == 0) stray_ack(16'($urandom));
      end

      // Reset while counting with the strobe held low.
      tick();
      cpu_a    = 23'h003000;
      cpu_rw   = 1'b1;
      cpu_as_n = 1'b0;
      start    = cyc + 1;
      wait_until(start + 1);
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      m_dout = 16'hFFFF;
      m_to   = 1'b0;
      chk_reset_vals("midreset");
      repeat (5) tick();
      release_bus();
      repeat (2) tick();
      bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23'h000700, 4, 0, 16'h600D);
      bus_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 23'h400010, 0, 0, 16'h0);

      repeat (4) tick();
      while (evq.size() > 0) begin
         ev_t e;
         e = evq.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: kind %0d expected at cycle %0d never seen", e.kind, e.cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
